// File: rtl/mastermind_game_ctrl_if.sv
// Grader handshake bundle: the controller drives the request and latched guess,
// the grader answers with an ack and the exact-match count.
interface mastermind_game_ctrl_if;
  logic        gradeReq;
  logic [11:0] gradeGuess;
  logic        gradeAck;
  logic [2:0]  Znarly;

  modport master (output gradeReq, output gradeGuess, input gradeAck, input Znarly);
  modport slave  (input gradeReq, input gradeGuess, output gradeAck, output Znarly);
endinterface

// File: rtl/mastermind_game_ctrl.sv
// Mastermind game sequencer: credit tracking, master-pattern load, guess
// submission to the grader and win/loss decision.
//
// state | meaning
// IDLE  | waiting for a paid start
// LOAD  | master pattern slots being written
// PLAY  | waiting for a GradeIt rising edge
// GRADE | guess presented to grader, waiting for ack
// WON   | last guess matched all four slots
// LOST  | round limit reached without a match
module mastermind_game_ctrl #(
  parameter int MAX_GAMES  = 7,
  parameter int MAX_ROUNDS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        gamePaid,
  input  logic        startGame,
  input  logic [2:0]  LoadShape,
  input  logic [1:0]  ShapeLocation,
  input  logic        LoadShapeNow,
  input  logic        GradeIt,
  input  logic [11:0] GuessPattern,
  output logic [3:0]  numGames,
  output logic [3:0]  RoundNumber,
  output logic [11:0] MasterPattern,
  output logic        loadingMaster,
  output logic        GameWon,
  output logic        GameLost,
  mastermind_game_ctrl_if.master grd
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PLAY, S_GRADE, S_WON, S_LOST
  } state_t;

  localparam logic [3:0] MaxGames  = 4'(MAX_GAMES);
  localparam logic [3:0] MaxRounds = 4'(MAX_ROUNDS);

  state_t      state_q;
  logic [3:0]  numGames_q, numGames_d;
  logic [3:0]  round_q;
  logic [11:0] master_q;
  logic [11:0] guess_q;
  logic [3:0]  mask_q;
  logic        req_q, loading_q, won_q, lost_q;
  logic        gradeit_prev_q;
  logic        start_ok, grade_edge;

  // Start acceptance looks only at the registered credit count.
  always_comb begin
    start_ok   = (state_q inside {S_IDLE, S_WON, S_LOST}) && startGame && (numGames_q != 4'd0);
    grade_edge = GradeIt && !gradeit_prev_q;
    numGames_d = numGames_q;
    if (start_ok && !gamePaid)
      numGames_d = numGames_q - 4'd1;
    else if (!start_ok && gamePaid && (numGames_q != MaxGames))
      numGames_d = numGames_q + 4'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      numGames_q     <= 4'd0;
      round_q        <= 4'd0;
      master_q       <= 12'd0;
      guess_q        <= 12'd0;
      mask_q         <= 4'd0;
      req_q          <= 1'b0;
      loading_q      <= 1'b0;
      won_q          <= 1'b0;
      lost_q         <= 1'b0;
      gradeit_prev_q <= 1'b0;
    end else begin
      numGames_q     <= numGames_d;
      gradeit_prev_q <= GradeIt;
      case (state_q)
        S_IDLE, S_WON, S_LOST: begin
          if (start_ok) begin
            state_q   <= S_LOAD;
            loading_q <= 1'b1;
            won_q     <= 1'b0;
            lost_q    <= 1'b0;
            round_q   <= 4'd0;
            master_q  <= 12'd0;
            mask_q    <= 4'd0;
          end
        end
        S_LOAD: begin
          // The full mask is seen one cycle after the last write, giving the N+1 exit.
          if (mask_q == 4'hF) begin
            state_q   <= S_PLAY;
            loading_q <= 1'b0;
          end else if (LoadShapeNow) begin
            master_q[int'(ShapeLocation)*3 +: 3] <= LoadShape;
            mask_q[ShapeLocation]                <= 1'b1;
          end
        end
        S_PLAY: begin
          if (grade_edge) begin
            guess_q <= GuessPattern;
            round_q <= round_q + 4'd1;
            req_q   <= 1'b1;
            state_q <= S_GRADE;
          end
        end
        S_GRADE: begin
          if (grd.gradeAck) begin
            req_q <= 1'b0;
            if (grd.Znarly == 3'd4) begin
              state_q <= S_WON;
              won_q   <= 1'b1;
            end else if (round_q == MaxRounds) begin
              state_q <= S_LOST;
              lost_q  <= 1'b1;
            end else begin
              state_q <= S_PLAY;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign numGames       = numGames_q;
  assign RoundNumber    = round_q;
  assign MasterPattern  = master_q;
  assign loadingMaster  = loading_q;
  assign GameWon        = won_q;
  assign GameLost       = lost_q;
  assign grd.gradeReq   = req_q;
  assign grd.gradeGuess = guess_q;

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// Directed bench for mastermind_game_ctrl: credits, load, grading, win/loss, reset.
module tb_mastermind_game_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        gamePaid = 1'b0, startGame = 1'b0, LoadShapeNow = 1'b0, GradeIt = 1'b0;
  logic [2:0]  LoadShape = 3'd0;
  logic [1:0]  ShapeLocation = 2'd0;
  logic [11:0] GuessPattern = 12'd0;
  logic [3:0]  numGames, RoundNumber;
  logic [11:0] MasterPattern;
  logic        loadingMaster, GameWon, GameLost;

  int n_cmp = 0;
  int n_bad = 0;

  mastermind_game_ctrl_if grd_if ();

  mastermind_game_ctrl #(.MAX_GAMES(7), .MAX_ROUNDS(8)) dut (
    .clock(clock), .reset(reset), .gamePaid(gamePaid), .startGame(startGame),
    .LoadShape(LoadShape), .ShapeLocation(ShapeLocation), .LoadShapeNow(LoadShapeNow),
    .GradeIt(GradeIt), .GuessPattern(GuessPattern), .numGames(numGames),
    .RoundNumber(RoundNumber), .MasterPattern(MasterPattern), .loadingMaster(loadingMaster),
    .GameWon(GameWon), .GameLost(GameLost), .grd(grd_if.master)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_pattern(input logic [11:0] pat);
    LoadShapeNow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ShapeLocation = 2'(i);
      LoadShape = pat[3*i +: 3];
      step();
    end
    LoadShapeNow = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    grd_if.gradeAck = 1'b0;
    grd_if.Znarly = 3'd0;
    step();
    step();
    n_cmp++; if (numGames !== 4'd0) begin n_bad++; $display("FAIL reset_numGames: got %0d want 0", numGames); end
    n_cmp++; if (RoundNumber !== 4'd0) begin n_bad++; $display("FAIL reset_round: got %0d want 0", RoundNumber); end
    n_cmp++; if (MasterPattern !== 12'd0 || grd_if.gradeGuess !== 12'd0) begin n_bad++; $display("FAIL reset_patterns: got %h/%h want 0/0", MasterPattern, grd_if.gradeGuess); end
    n_cmp++; if ({grd_if.gradeReq, loadingMaster, GameWon, GameLost} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {grd_if.gradeReq, loadingMaster, GameWon, GameLost}); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_credits();
    gamePaid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    n_cmp++; if (numGames !== 4'd3) begin n_bad++; $display("FAIL credits_3: got %0d want 3", numGames); end
    for (int i = 0; i < 6; i++) step();
    n_cmp++; if (numGames !== 4'd7) begin n_bad++; $display("FAIL credits_sat: got %0d want 7", numGames); end
    startGame = 1'b1;
    step();
    startGame = 1'b0;
    gamePaid = 1'b0;
    n_cmp++; if (numGames !== 4'd7) begin n_bad++; $display("FAIL credits_paid_and_start: got %0d want 7", numGames); end
    n_cmp++; if (loadingMaster !== 1'b1) begin n_bad++; $display("FAIL start_load: got %b want 1", loadingMaster); end
  endtask

  task automatic test_load();
    logic [1:0] locs [5] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
    logic [2:0] shps [5] = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd4};
    LoadShapeNow = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ShapeLocation = locs[i];
      LoadShape = shps[i];
      step();
      if (i == 3) begin
        n_cmp++; if (loadingMaster !== 1'b1) begin n_bad++; $display("FAIL load_not_done_early: got %b want 1", loadingMaster); end
      end
    end
    LoadShapeNow = 1'b0;
    n_cmp++; if (MasterPattern !== 12'b100_011_101_001) begin n_bad++; $display("FAIL load_pattern: got %b want 100011101001", MasterPattern); end
    n_cmp++; if (loadingMaster !== 1'b1) begin n_bad++; $display("FAIL load_hold_one_cycle: got %b want 1", loadingMaster); end
    step();
    n_cmp++; if (loadingMaster !== 1'b0) begin n_bad++; $display("FAIL load_exit: got %b want 0", loadingMaster); end
  endtask

  task automatic test_grade_win();
    GuessPattern = 12'hABC;
    GradeIt = 1'b1;
    step();
    GuessPattern = 12'h123;
    n_cmp++; if (grd_if.gradeReq !== 1'b1) begin n_bad++; $display("FAIL win_req: got %b want 1", grd_if.gradeReq); end
    n_cmp++; if (RoundNumber !== 4'd1) begin n_bad++; $display("FAIL win_round: got %0d want 1", RoundNumber); end
    n_cmp++; if (grd_if.gradeGuess !== 12'hABC) begin n_bad++; $display("FAIL win_guess: got %h want abc", grd_if.gradeGuess); end
    for (int i = 0; i < 4; i++) step();
    GradeIt = 1'b0;
    n_cmp++; if (grd_if.gradeReq !== 1'b1 || RoundNumber !== 4'd1) begin n_bad++; $display("FAIL win_single_submit: got req %b round %0d want 1 1", grd_if.gradeReq, RoundNumber); end
    grd_if.gradeAck = 1'b1;
    grd_if.Znarly = 3'd4;
    step();
    grd_if.gradeAck = 1'b0;
    n_cmp++; if (GameWon !== 1'b1 || grd_if.gradeReq !== 1'b0 || GameLost !== 1'b0) begin n_bad++; $display("FAIL win_result: got won %b req %b lost %b want 1 0 0", GameWon, grd_if.gradeReq, GameLost); end
    GradeIt = 1'b1;
    step();
    GradeIt = 1'b0;
    step();
    n_cmp++; if (RoundNumber !== 4'd1 || GameWon !== 1'b1 || grd_if.gradeGuess !== 12'hABC) begin n_bad++; $display("FAIL won_hold: got round %0d won %b guess %h want 1 1 abc", RoundNumber, GameWon, grd_if.gradeGuess); end
  endtask

  task automatic test_zero_credit();
    reset = 1'b1;
    step();
    reset = 1'b0;
    startGame = 1'b1;
    gamePaid = 1'b1;
    step();
    gamePaid = 1'b0;
    n_cmp++; if (loadingMaster !== 1'b0 || numGames !== 4'd1) begin n_bad++; $display("FAIL zero_credit_start: got load %b games %0d want 0 1", loadingMaster, numGames); end
    step();
    startGame = 1'b0;
    n_cmp++; if (loadingMaster !== 1'b1 || numGames !== 4'd0) begin n_bad++; $display("FAIL credit_then_start: got load %b games %0d want 1 0", loadingMaster, numGames); end
  endtask

  task automatic test_lose();
    load_pattern(12'o7531);
    n_cmp++; if (MasterPattern !== 12'o7531 || loadingMaster !== 1'b0) begin n_bad++; $display("FAIL lose_load: got %o load %b want 7531 0", MasterPattern, loadingMaster); end
    for (int r = 1; r <= 8; r++) begin
      GuessPattern = 12'(r);
      GradeIt = 1'b1;
      step();
      GradeIt = 1'b0;
      n_cmp++; if (RoundNumber !== 4'(r) || grd_if.gradeReq !== 1'b1) begin n_bad++; $display("FAIL lose_round_%0d: got round %0d req %b want %0d 1", r, RoundNumber, grd_if.gradeReq, r); end
      grd_if.gradeAck = 1'b1;
      grd_if.Znarly = (r == 3) ? 3'd5 : 3'd2;
      step();
      grd_if.gradeAck = 1'b0;
      if (r < 8) begin
        n_cmp++; if (GameLost !== 1'b0 || GameWon !== 1'b0 || grd_if.gradeReq !== 1'b0) begin n_bad++; $display("FAIL lose_early_%0d: got lost %b won %b req %b want 0 0 0", r, GameLost, GameWon, grd_if.gradeReq); end
      end
    end
    n_cmp++; if (GameLost !== 1'b1 || RoundNumber !== 4'd8 || GameWon !== 1'b0) begin n_bad++; $display("FAIL lose_result: got lost %b round %0d won %b want 1 8 0", GameLost, RoundNumber, GameWon); end
    gamePaid = 1'b1;
    step();
    gamePaid = 1'b0;
    startGame = 1'b1;
    step();
    startGame = 1'b0;
    n_cmp++; if (loadingMaster !== 1'b1 || RoundNumber !== 4'd0 || GameLost !== 1'b0 || MasterPattern !== 12'd0 || numGames !== 4'd0) begin n_bad++; $display("FAIL restart_after_loss: got load %b round %0d lost %b pat %h games %0d want 1 0 0 0 0", loadingMaster, RoundNumber, GameLost, MasterPattern, numGames); end
    n_cmp++; if (grd_if.gradeGuess !== 12'd8) begin n_bad++; $display("FAIL restart_guess_kept: got %h want 008", grd_if.gradeGuess); end
  endtask

  task automatic test_reset_midgame();
    load_pattern(12'o1234);
    gamePaid = 1'b1;
    step();
    step();
    gamePaid = 1'b0;
    GuessPattern = 12'h5A5;
    GradeIt = 1'b1;
    step();
    GradeIt = 1'b0;
    n_cmp++; if (grd_if.gradeReq !== 1'b1 || numGames !== 4'd2) begin n_bad++; $display("FAIL mid_pre_reset: got req %b games %0d want 1 2", grd_if.gradeReq, numGames); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({grd_if.gradeReq, loadingMaster, GameWon, GameLost} !== 4'b0000 || numGames !== 4'd0 || RoundNumber !== 4'd0 || MasterPattern !== 12'd0 || grd_if.gradeGuess !== 12'd0) begin n_bad++; $display("FAIL mid_async_reset: got flags %b games %0d round %0d pat %h guess %h want 0000 0 0 0 0", {grd_if.gradeReq, loadingMaster, GameWon, GameLost}, numGames, RoundNumber, MasterPattern, grd_if.gradeGuess); end
    reset = 1'b0;
    grd_if.gradeAck = 1'b1;
    grd_if.Znarly = 3'd4;
    step();
    step();
    grd_if.gradeAck = 1'b0;
    n_cmp++; if (GameWon !== 1'b0 || grd_if.gradeReq !== 1'b0 || GameLost !== 1'b0) begin n_bad++; $display("FAIL mid_ack_ignored: got won %b req %b lost %b want 0 0 0", GameWon, grd_if.gradeReq, GameLost); end
  endtask

  initial begin
    test_reset();
    test_credits();
    test_load();
    test_grade_win();
    test_zero_credit();
    test_lose();
    test_reset_midgame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mastermind_game_ctrl.md
# mastermind_game_ctrl

Game-sequencing controller for the coin-operated Mastermind datapath. Tracks purchased game credits, sequences loading of the 4-shape master pattern, issues guesses to the external grader over a req/ack handshake, counts rounds and declares win or loss. Sits between the coin/credit FSM (source of `gamePaid`) and the pattern grader.

## Interface
- `MAX_GAMES`, 7, saturation limit of stored game credits (1..15)
- `MAX_ROUNDS`, 8, guesses allowed per game (1..15)

- `clock` in 1, single clock; all state updates on posedge
- `reset` in 1, asynchronous, active-high; clears all state
- `gamePaid` in 1, one-cycle pulse: one game purchased
- `startGame` in 1, request to begin a game (level, sampled each cycle)
- `LoadShape` in 3, shape code to write into master pattern
- `ShapeLocation` in 2, slot index 0..3; slot i = `MasterPattern[3i+2:3i]`
- `LoadShapeNow` in 1, write strobe for LoadShape/ShapeLocation
- `GradeIt` in 1, player submits `GuessPattern`; rising edge only
- `GuessPattern` in 12, current guess
- `gradeAck` in 1, grader done; `Znarly` valid same cycle
- `Znarly` in 3, exact-position matches 0..4
- `numGames` out 4, stored credits
- `RoundNumber` out 4, guesses submitted this game
- `MasterPattern` out 12, registered master pattern
- `gradeGuess` out 12, guess latched for grader
- `gradeReq` out 1, grade request, held until ack
- `loadingMaster` out 1, high in LOAD
- `GameWon` out 1, high in WON
- `GameLost` out 1, high in LOST

## Operation
- States: IDLE, LOAD, PLAY, GRADE, WON, LOST. Reset → IDLE.
- Credits: `gamePaid` increments `numGames`, saturating at MAX_GAMES. Game start decrements. Both in one cycle → net unchanged (at MAX stays MAX). Start acceptance uses registered `numGames` only: at 0, a same-cycle `gamePaid` does not enable start.
- Start accept: in IDLE, WON or LOST with `startGame`=1 and `numGames`≠0 → LOAD; `RoundNumber`←0, `MasterPattern`←0, 4-bit loaded mask←0, `gradeGuess` unchanged. `numGames`=0: start ignored, state held. `startGame` ignored in LOAD/PLAY/GRADE.
- LOAD: `LoadShapeNow`=1 writes `LoadShape` into slot `ShapeLocation`, sets mask bit; rewriting a slot overwrites, counts once. Mask becomes 4'b1111 → PLAY next cycle. `LoadShapeNow` ignored outside LOAD.
- GradeIt edge: registered `GradeIt` delayed copy, tracked in all states; edge = `GradeIt`&~prev.
- PLAY: edge → latch `gradeGuess`←`GuessPattern`, `RoundNumber`+1, go GRADE. Held-high `GradeIt` produces one submission only.
- GRADE: `gradeReq`=1 throughout. On `gradeAck`: `Znarly`==4 → WON; else `RoundNumber`==MAX_ROUNDS → LOST; else PLAY. Edges in GRADE are dropped. `gradeAck` outside GRADE ignored.
- WON/LOST: outputs held (pattern, round count) until accepted start.
- `Znarly` > 4 treated as not-won.

## Timing
- All outputs registered; reset values: state IDLE, `numGames`=0, `RoundNumber`=0, `MasterPattern`=0, `gradeGuess`=0, `gradeReq`=0, `loadingMaster`=0, `GameWon`=0, `GameLost`=0.
- Start sampled at edge N → `loadingMaster`=1, `numGames` decremented after N.
- 4th slot write at edge N → PLAY after N+1 (`loadingMaster` low after N+1).
- `GradeIt` edge sampled at N → `gradeReq`=1, `RoundNumber` updated after N. Ack sampled at M → `gradeReq`=0 and `GameWon`/`GameLost`/PLAY after M. Ack in the first `gradeReq` cycle legal: minimum round trip 2 cycles.
- Reset mid-game (any state, any cycle): immediate clear to reset values; credits lost.

## Test plan
- Reset, 3 `gamePaid` pulses → `numGames`=3; 6 more → saturates at 7; `gamePaid`+start together at 7 → stays 7, enters LOAD.
- `numGames`=0, `startGame`=1 with same-cycle `gamePaid` → stays IDLE, `numGames`=1; next cycle start → LOAD, `numGames`=0.
- LOAD writes slots 0,1,1,2,3 with shapes 1,2,5,3,4 → `MasterPattern`=12'b100_011_101_001, PLAY one cycle after slot 3 write.
- PLAY, `GradeIt` held 5 cycles → one `gradeReq`, `RoundNumber`=1; ack after 3 cycles with `Znarly`=4 → `GameWon`=1, `gradeReq`=0.
- MAX_ROUNDS=8, eight guesses acked with `Znarly`=2 → `GameLost`=1 after 8th ack, `RoundNumber`=8; then start with credit → LOAD, `RoundNumber`=0.
- Assert `reset` while `gradeReq`=1 in GRADE → all outputs to reset values asynchronously; subsequent `gradeAck` ignored.
